// File: rtl/ddr_align_pkg.sv
// Shared state encoding and constants for the DDR word aligner.
package ddr_align_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } align_state_e;

  localparam int unsigned ErrCntWidth = 8;

endpackage

// File: rtl/ddr_window_match.sv
// Compares both candidate word windows of the DDR shift register against the sync pattern.
module ddr_window_match #(
  parameter int unsigned           WORD_WIDTH   = 16,
  parameter logic [WORD_WIDTH-1:0] SYNC_PATTERN = 16'h9A5C
) (
  input  logic [WORD_WIDTH:0] sreg_i,
  output logic                match_a,
  output logic                match_b
);

  // Window A ends on the latest (Q2) bit, window B ends one bit earlier (Q1).
  assign match_a = (sreg_i[WORD_WIDTH-1:0] == SYNC_PATTERN);
  assign match_b = (sreg_i[WORD_WIDTH:1] == SYNC_PATTERN);

endmodule

// File: rtl/ddr_word_aligner.sv
// Assembles DDR bit pairs into aligned words: hunt for sync at either phase, verify, then emit.
// Define DDR_ALIGN_ERR_CNT_EN to build the saturating failed-lock counter on ERR_CNT.
module ddr_word_aligner
  import ddr_align_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH   = 16,
  parameter logic [WORD_WIDTH-1:0] SYNC_PATTERN = 16'h9A5C,
  parameter int unsigned           LOCK_COUNT   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   DDR_Q1,
  input  logic                   DDR_Q2,
  input  logic                   RESYNC,
  output logic [WORD_WIDTH-1:0]  DATA_OUT,
  output logic                   DATA_VALID,
  output logic                   LOCKED,
  output logic                   BIT_PHASE,
  output logic [ErrCntWidth-1:0] ERR_CNT
);

  localparam int unsigned Half = WORD_WIDTH / 2;
  localparam int unsigned PhW  = (Half > 1) ? $clog2(Half) : 1;
  localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

  if ((WORD_WIDTH % 2) != 0 || WORD_WIDTH < 4) begin : g_bad_width
    $error("WORD_WIDTH must be even and at least 4");
  end
  if (LOCK_COUNT < 1) begin : g_bad_lock
    $error("LOCK_COUNT must be at least 1");
  end
  if (SYNC_PATTERN == '0 || SYNC_PATTERN == '1) begin : g_bad_sync
    $error("SYNC_PATTERN must be neither all-zeros nor all-ones");
  end

  logic [WORD_WIDTH:0]   sreg_q;
  align_state_e          state_q, state_d;
  logic [PhW-1:0]        ph_q, ph_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  bit_phase_q, bit_phase_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  match_a, match_b;
  logic [WORD_WIDTH-1:0] win_sel;
  logic                  sel_match;
  logic                  boundary;

  ddr_window_match #(
    .WORD_WIDTH   (WORD_WIDTH),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_window_match (
    .sreg_i  (sreg_q),
    .match_a (match_a),
    .match_b (match_b)
  );

  assign win_sel   = bit_phase_q ? sreg_q[WORD_WIDTH:1] : sreg_q[WORD_WIDTH-1:0];
  assign sel_match = bit_phase_q ? match_b : match_a;
  // The match cycle loads the counter with 1, so it returns to 0 exactly Half cycles later.
  assign boundary  = (ph_q == '0);
  assign cnt_inc   = cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    ph_d        = (ph_q == PhW'(Half - 1)) ? '0 : ph_q + PhW'(1);
    cnt_d       = cnt_q;
    bit_phase_d = bit_phase_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    if (RESYNC) begin
      state_d = StHunt;
      ph_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (match_a || match_b) begin
            bit_phase_d = !match_a;
            cnt_d       = CntW'(1);
            ph_d        = PhW'(1);
            state_d     = (LOCK_COUNT == 1) ? StLocked : StVerify;
          end
        end
        StVerify: begin
          if (boundary) begin
            if (sel_match) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CntW'(LOCK_COUNT)) state_d = StLocked;
            end else begin
              state_d = StHunt;
            end
          end
        end
        StLocked: begin
          if (boundary) begin
            data_d  = win_sel;
            valid_d = 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sreg_q      <= '0;
      state_q     <= StHunt;
      ph_q        <= '0;
      cnt_q       <= '0;
      bit_phase_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      sreg_q      <= {sreg_q[WORD_WIDTH-2:0], DDR_Q1, DDR_Q2};
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      bit_phase_q <= bit_phase_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

`ifdef DDR_ALIGN_ERR_CNT_EN
  logic [ErrCntWidth-1:0] err_q;
  logic                   err_inc;

  assign err_inc = !RESYNC && (state_q == StVerify) && boundary && !sel_match;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= '0;
    end else if (err_inc && err_q != '1) begin
      err_q <= err_q + ErrCntWidth'(1);
    end
  end

  assign ERR_CNT = err_q;
`else
  assign ERR_CNT = '0;
`endif

  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign LOCKED     = (state_q == StLocked);
  assign BIT_PHASE  = bit_phase_q;

endmodule
